// File: rtl/uart_pkt_arb_if.sv
// Handshake bundle between the two word sources, the arbiter and the UART_tx instance.
// The master side is the source and UART environment, and the slave side is the arbiter.
interface uart_pkt_arb_if;
  logic        req0;
  logic [15:0] data0;
  logic        ack0;
  logic        req1;
  logic [15:0] data1;
  logic        ack1;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        busy;
  logic        gnt_id;

  modport master (
    output req0, data0, req1, data1, tx_done,
    input  ack0, ack1, tx_data, trmt, busy, gnt_id
  );

  modport slave (
    input  req0, data0, req1, data1, tx_done,
    output ack0, ack1, tx_data, trmt, busy, gnt_id
  );
endinterface

// File: rtl/uart_pkt_arb.sv
// Round-robin arbiter that shares one UART transmitter between two 16-bit word sources.
// Each word is sent high byte first, and an enforced idle gap follows every packet.
module uart_pkt_arb #(
  parameter int GAP_W = 14
) (
  input logic           clk,
  input logic           rst_n,
  uart_pkt_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state_q, state_d;
  logic [15:0]        word_q, word_d;
  logic [GAP_W-1:0]   gap_q;
  logic               gap_clr;
  logic               gap_ok;
  logic               last_gnt_q, last_gnt_d;
  logic               gnt_q, gnt_d;
  logic               tx_done_q;
  logic               done_edge;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               trmt_q, trmt_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               winner;

  assign gap_ok    = &gap_q;
  assign done_edge = bus.tx_done & ~tx_done_q;

  // On a tie, the source that did not win last time gets the grant.
  assign winner = (bus.req0 & bus.req1) ? ~last_gnt_q : bus.req1;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    tx_data_d  = tx_data_q;
    trmt_d     = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    gap_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gap_ok && (bus.req0 || bus.req1)) begin
          word_d     = winner ? bus.data1 : bus.data0;
          gnt_d      = winner;
          last_gnt_d = winner;
          tx_data_d  = winner ? bus.data1[15:8] : bus.data0[15:8];
          trmt_d     = 1'b1;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (done_edge) begin
          tx_data_d = word_q[7:0];
          trmt_d    = 1'b1;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (done_edge) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          gap_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      tx_data_q  <= '0;
      trmt_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= trmt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      tx_done_q  <= bus.tx_done;
      if (gap_clr)
        gap_q <= '0;
      else if (!gap_ok)
        gap_q <= gap_q + GAP_W'(1);
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.trmt    = trmt_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.gnt_id  = gnt_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_pkt_arb.sv
// Scoreboard bench for uart_pkt_arb: stimulus queues expected bytes/acks, a monitor checks them.
// A small UART_tx model answers each trmt with tx_done in either pulse or level style.
module tb_uart_pkt_arb;
  localparam int GAP_W = 4;
  localparam int LAT   = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_pkt_arb_if bus ();

  uart_pkt_arb #(.GAP_W(GAP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       hi;
    logic       id;
  } byte_exp_t;

  byte_exp_t byte_q[$];
  logic      ack_q[$];
  int        vectors     = 0;
  int        miscompares = 0;
  int        cyc;
  int        ack_seen    = 0;
  int        trmt_seen   = 0;
  bit        level_mode  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic id, input logic [15:0] w);
    byte_exp_t e;
    e.b = w[15:8]; e.hi = 1'b1; e.id = id;
    byte_q.push_back(e);
    e.b = w[7:0];  e.hi = 1'b0; e.id = id;
    byte_q.push_back(e);
    ack_q.push_back(id);
  endtask

  task automatic wait_acks(input int n);
    int start;
    start = ack_seen;
    for (int i = 0; i < 400 && ack_seen < start + n; i++) @(posedge clk);
    chk("ack_wait", 32'(ack_seen - start >= n), 1);
    @(negedge clk);
  endtask

  task automatic wait_trmts(input int n);
    int start;
    start = trmt_seen;
    for (int i = 0; i < 400 && trmt_seen < start + n; i++) @(posedge clk);
    chk("trmt_wait", 32'(trmt_seen - start >= n), 1);
    @(negedge clk);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // UART_tx stand-in: tx_done rises LAT cycles after trmt; level style holds it until the next trmt.
  initial begin : uart_model
    int cnt;
    cnt = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        bus.tx_done = 1'b0;
      end else if (bus.trmt) begin
        cnt = LAT;
        bus.tx_done = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.tx_done = 1'b1;
      end else if (!level_mode) begin
        bus.tx_done = 1'b0;
      end
    end
  end

  initial begin : monitor
    int        last_ack;
    int        pkts;
    bit        prev_trmt;
    byte_exp_t e;
    logic      eid;
    last_ack = -1; pkts = 0; prev_trmt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_ack = -1; pkts = 0; prev_trmt = 1'b0;
      end else begin
        if (bus.trmt) begin
          trmt_seen++;
          chk("trmt_one_cycle", 32'(prev_trmt), 0);
          if (byte_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_byte: got tx_data %0h expected no byte", bus.tx_data);
          end else begin
            e = byte_q.pop_front();
            chk("tx_data", bus.tx_data, e.b);
            chk("gnt_id", 32'(bus.gnt_id), 32'(e.id));
            chk("busy_in_pkt", 32'(bus.busy), 1);
            if (e.hi) begin
              // Grant needs 2^GAP_W-1 increments from zero, then one edge to launch trmt.
              if (pkts == 0) chk("first_grant_cycle", cyc, 2**GAP_W);
              else           chk("gap_respected", 32'(cyc - last_ack >= 2**GAP_W), 1);
              pkts++;
            end
          end
        end
        prev_trmt = bus.trmt;
        if (bus.ack0 || bus.ack1) begin
          ack_seen++;
          if (ack_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_ack: got {ack1,ack0}=%b%b expected none", bus.ack1, bus.ack0);
          end else begin
            eid = ack_q.pop_front();
            chk("ack_onehot", 32'({bus.ack1, bus.ack0}), eid ? 32'd2 : 32'd1);
            chk("busy_at_ack", 32'(bus.busy), 0);
          end
          last_ack = cyc;
        end
      end
    end
  end

  initial begin : stim
    bus.data0 = '0;
    bus.data1 = '0;
    hold_reset();
    #1;
    chk("rst_trmt",    32'(bus.trmt), 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_ack0",    32'(bus.ack0), 0);
    chk("rst_ack1",    32'(bus.ack1), 0);
    chk("rst_busy",    32'(bus.busy), 0);
    chk("rst_gnt_id",  32'(bus.gnt_id), 0);

    // Lone source 0 request held through reset release.
    @(negedge clk);
    bus.req0 = 1'b1; bus.data0 = 16'hA55A;
    push_pkt(1'b0, 16'hA55A);
    rst_n = 1'b1;
    wait_acks(1);
    bus.req0 = 1'b0;
    chk("gnt_id_after_pkt", 32'(bus.gnt_id), 0);

    // Both sources held with level-style tx_done: grants alternate 0,1,0,1.
    hold_reset();
    level_mode = 1'b1;
    bus.req0 = 1'b1; bus.data0 = 16'h1111;
    bus.req1 = 1'b1; bus.data1 = 16'h2222;
    push_pkt(1'b0, 16'h1111);
    push_pkt(1'b1, 16'h2222);
    push_pkt(1'b0, 16'h1111);
    push_pkt(1'b1, 16'h2222);
    rst_n = 1'b1;
    wait_acks(4);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (40) @(negedge clk);
    level_mode = 1'b0;

    // Data changing after grant must not alter the bytes sent.
    hold_reset();
    bus.req0 = 1'b1; bus.data0 = 16'h1234;
    push_pkt(1'b0, 16'h1234);
    rst_n = 1'b1;
    wait_trmts(1);
    bus.data0 = 16'hFFFF;
    wait_acks(1);
    bus.req0 = 1'b0;

    // Reset while the low byte is in flight abandons the packet.
    hold_reset();
    bus.req0 = 1'b1; bus.data0 = 16'hBEEF;
    push_pkt(1'b0, 16'hBEEF);
    rst_n = 1'b1;
    wait_trmts(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_trmt", 32'(bus.trmt), 0);
    chk("midrst_ack0", 32'(bus.ack0), 0);
    chk("midrst_ack1", 32'(bus.ack1), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    if (ack_q.size() > 0) void'(ack_q.pop_back());
    bus.data0 = 16'h7788;
    push_pkt(1'b0, 16'h7788);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_acks(1);
    bus.req0 = 1'b0;

    // Source 1 drops its request mid-packet; then a lone source 0 request.
    hold_reset();
    bus.req1 = 1'b1; bus.data1 = 16'hC33C;
    push_pkt(1'b1, 16'hC33C);
    rst_n = 1'b1;
    wait_trmts(1);
    bus.req1 = 1'b0;
    wait_acks(1);
    bus.req0 = 1'b1; bus.data0 = 16'h0FF0;
    push_pkt(1'b0, 16'h0FF0);
    wait_acks(1);
    bus.req0 = 1'b0;

    repeat (30) @(negedge clk);
    chk("bytes_outstanding", byte_q.size(), 0);
    chk("acks_outstanding",  ack_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_pkt_arb.md
# uart_pkt_arb

Round-robin arbiter and packet sequencer that shares a single UART transmitter between two 16-bit word sources. Each granted word goes out as two bytes, high byte first, followed by an enforced idle gap before the next packet. The block sits between the stimulus/telemetry sources and the UART_tx instance, driving its trmt/tx_data and consuming its tx_done.

## Interface
- GAP_W, 14, width of the inter-packet gap counter; minimum gap is 2^GAP_W-1 clocks.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  source 0 requests a packet; held high until ack0
- data0  input  16  source 0 word; must be stable while req0 high and not yet granted
- ack0  output  1  one-cycle pulse: source 0 packet fully transmitted
- req1  input  1  source 1 request, same rules as req0
- data1  input  16  source 1 word
- ack1  output  1  one-cycle pulse: source 1 packet complete
- tx_data  output  8  byte to UART_tx, registered
- trmt  output  1  one-cycle start pulse to UART_tx, registered
- tx_done  input  1  UART_tx byte-complete flag (pulse or level accepted)
- busy  output  1  high while a packet is in progress (state != IDLE)
- gnt_id  output  1  index of the source owning the current/last packet

## Operation
- States: IDLE, HIGH (high byte in flight), LOW (low byte in flight).
- Gap counter: GAP_W bits, reset 0, increments every cycle, saturates at all-ones (no wrap); gap_ok = all-ones. Cleared to 0 on the cycle a packet completes.
- done_edge = tx_done & ~tx_done_q; tx_done_q is a register of tx_done, reset 0. All tx_done decisions use done_edge only.
- IDLE: if gap_ok and (req0 or req1): select winner, latch winner's data into a 16-bit word register, gnt_id <= winner, tx_data <= data[15:8], trmt <= 1, go to HIGH. Otherwise stay.
- Arbitration: single requester wins outright. Both requesting: grant the source not equal to last_gnt. last_gnt is updated at grant and resets to 1, so source 0 wins the first tie.
- HIGH: on done_edge, tx_data <= word[7:0], trmt <= 1, go to LOW.
- LOW: on done_edge, pulse ack of gnt_id for one cycle (registered), clear gap counter, go to IDLE.
- trmt is high for exactly one cycle per byte. tx_data holds its value until the next byte is loaded.
- Requester dropping req mid-packet does not abort the packet. Both bytes are still sent and the ack is still pulsed.
- done_edge in IDLE is ignored.
- Data change after grant has no effect because the word is latched at grant.

## Timing
- Reset values: state IDLE, trmt 0, tx_data 8'h00, ack0/ack1 0, busy 0, gnt_id 0, last_gnt 1, gap counter 0, word 0, tx_done_q 0.
- Reset asserted mid-packet: returns immediately to IDLE. The partial packet is abandoned, no ack is given, and the gap restarts from 0.
- Grant latency: trmt rises on the clock edge following the cycle where gap_ok and a req are both seen.
- Byte turnaround: the second trmt rises one clock after the cycle in which the tx_done rising edge is sampled.
- ack is asserted on the clock edge after the low-byte done_edge. busy falls on the same edge.
- First packet after reset can start no earlier than cycle 2^GAP_W-1.
- Back-to-back packets are separated by at least 2^GAP_W-1 clocks measured from ack.
- Requester must deassert req on the cycle after ack unless it has a new word ready. The gap prevents a double grant of a stale request.

## Test plan
- GAP_W=4, req0=1, data0=16'hA55A after reset: trmt at cycle 16 with tx_data 8'hA5, then 8'h5A after the first tx_done, then one ack0 pulse, gnt_id=0.
- req0 and req1 both held continuously with data0=16'h1111 and data1=16'h2222: packets alternate 0,1,0,1, starting with source 0. Each gap is ≥15 cycles and acks alternate.
- Level-style tx_done that stays high between bytes: exactly two trmt pulses per packet, with no spurious byte.
- data0 changes to 16'hFFFF one cycle after grant: bytes sent remain the original latched value.
- rst_n pulsed low while in LOW state: trmt/ack stay 0, busy=0 immediately, and the next packet waits a full gap.
- req1 dropped while HIGH: low byte still sent and ack1 still pulses. A subsequent lone req0 is granted after the gap.
